// File: rtl/abs_diff_sad.sv
// abs_diff_sad: streaming sum-of-absolute-differences engine.
// Per-beat lane |x-y| summed, accumulated per frame, one result per frame.
module abs_diff_sad #(
    parameter int WIDTH     = 10,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_x,
    input  logic [LANES*WIDTH-1:0] in_y,
    input  logic                   in_last,
    input  logic [ACC_WIDTH-1:0]   threshold,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sad,
    output logic [CNT_WIDTH-1:0]   out_count,
    output logic                   out_below,
    output logic                   out_overflow
);

    localparam int SUM_W = WIDTH + $clog2(LANES);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    logic adv;

    logic [WIDTH-1:0] d_in [LANES];
    logic [WIDTH-1:0] s1_d [LANES];
    logic             s1_valid;
    logic             s1_last;

    logic [SUM_W-1:0] lane_sum;
    logic [SUM_W-1:0] s2_sum;
    logic             s2_valid;
    logic             s2_last;

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   ovf;
    logic [ACC_WIDTH-1:0]   acc_base;
    logic [CNT_WIDTH-1:0]   cnt_base;
    logic                   ovf_base;
    logic [ACC_WIDTH:0]     acc_wide;
    logic [CNT_WIDTH:0]     cnt_wide;
    logic                   acc_sat;
    logic                   cnt_sat;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic                   ovf_nxt;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   ovf_d;
    logic                   step;
    logic                   emit;

    // One global stall: nothing moves while a result waits unconsumed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Per-lane absolute difference of the incoming beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (in_x[i*WIDTH +: WIDTH] > in_y[i*WIDTH +: WIDTH])
                d_in[i] = in_x[i*WIDTH +: WIDTH] - in_y[i*WIDTH +: WIDTH];
            else
                d_in[i] = in_y[i*WIDTH +: WIDTH] - in_x[i*WIDTH +: WIDTH];
        end
    end

    // S1: register lane differences; payload only loads on a real beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < LANES; i++)
                s1_d[i] <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= in_last;
                for (int i = 0; i < LANES; i++)
                    s1_d[i] <= d_in[i];
            end
        end
    end

    // Lane reduction; width is sized so the sum is always exact.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + SUM_W'(s1_d[i]);
    end

    // S2: register the beat sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_sum  <= lane_sum;
            end
        end
    end

    // Saturating accumulate/count; IDLE always starts a frame from zero.
    always_comb begin
        acc_base = (state == IDLE) ? '0 : acc;
        cnt_base = (state == IDLE) ? '0 : cnt;
        ovf_base = (state == IDLE) ? 1'b0 : ovf;
        acc_wide = {1'b0, acc_base} + (ACC_WIDTH+1)'(s2_sum);
        cnt_wide = {1'b0, cnt_base} + (CNT_WIDTH+1)'(1);
        acc_sat  = acc_wide[ACC_WIDTH];
        cnt_sat  = cnt_wide[CNT_WIDTH];
        acc_nxt  = acc_sat ? '1 : acc_wide[ACC_WIDTH-1:0];
        cnt_nxt  = cnt_sat ? '1 : cnt_wide[CNT_WIDTH-1:0];
        ovf_nxt  = ovf_base | acc_sat | cnt_sat;
    end

    // Frame FSM: next state plus accumulator updates.
    always_comb begin
        step      = s2_valid && adv;
        emit      = step && s2_last;
        state_nxt = state;
        acc_d     = acc;
        cnt_d     = cnt;
        ovf_d     = ovf;
        case (state)
            IDLE: begin
                if (step && !s2_last) begin
                    state_nxt = ACCUM;
                    acc_d     = acc_nxt;
                    cnt_d     = cnt_nxt;
                    ovf_d     = ovf_nxt;
                end
            end
            ACCUM: begin
                if (step) begin
                    if (s2_last) begin
                        state_nxt = IDLE;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                    end else begin
                        acc_d     = acc_nxt;
                        cnt_d     = cnt_nxt;
                        ovf_d     = ovf_nxt;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end
        endcase
    end

    // Frame state and running totals.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_d;
            cnt   <= cnt_d;
            ovf   <= ovf_d;
        end
    end

    // Result register: load on emit, otherwise clear valid when taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_sad      <= '0;
            out_count    <= '0;
            out_below    <= 1'b0;
            out_overflow <= 1'b0;
        end else if (emit) begin
            out_valid    <= 1'b1;
            out_sad      <= acc_nxt;
            out_count    <= cnt_nxt;
            out_below    <= (acc_nxt < threshold);
            out_overflow <= ovf_nxt;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule
